// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator.
// Turns one-word read/write commands into AXI-Lite transactions and returns
// each result as a one-cycle response pulse; a per-transaction timeout
// aborts transactions to hung targets.
module axi_lite_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // command / response interface
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    // AXI write address / data / response channels
    output logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wdata,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    // AXI read address / data channels
    output logic [C_M_AXI_ADDR_WIDTH-1:0] araddr,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t                        r_state,       w_state;
    logic [CW-1:0]                 r_cnt,         w_cnt;
    logic                          r_aw_done,     w_aw_done;
    logic                          r_w_done,      w_w_done;
    logic                          r_cmd_ready,   w_cmd_ready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr,      w_awaddr;
    logic                          r_awvalid,     w_awvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata,       w_wdata;
    logic                          r_wvalid,      w_wvalid;
    logic                          r_bready,      w_bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr,      w_araddr;
    logic                          r_arvalid,     w_arvalid;
    logic                          r_rready,      w_rready;
    logic                          r_rsp_valid,   w_rsp_valid;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata;
    logic [1:0]                    r_rsp_resp,    w_rsp_resp;
    logic                          r_rsp_timeout, w_rsp_timeout;

    logic w_expire;
    logic w_abort;
    logic w_aw_hs;
    logic w_w_hs;

    // Expiry is evaluated against the count before this edge's increment.
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));
    assign w_aw_hs  = r_awvalid & awready;
    assign w_w_hs   = r_wvalid & wready;

    // Next-state and next-output logic; B/R handshakes take priority over expiry.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt + CW'(1);
        w_aw_done     = r_aw_done;
        w_w_done      = r_w_done;
        w_cmd_ready   = r_cmd_ready;
        w_awaddr      = r_awaddr;
        w_awvalid     = r_awvalid;
        w_wdata       = r_wdata;
        w_wvalid      = r_wvalid;
        w_bready      = r_bready;
        w_araddr      = r_araddr;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_resp    = r_rsp_resp;
        w_rsp_timeout = r_rsp_timeout;
        w_abort       = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt       = '0;
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    if (cmd_write) begin
                        w_state   = WR_REQ;
                        w_awaddr  = cmd_addr;
                        w_wdata   = cmd_wdata;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_done = 1'b0;
                        w_w_done  = 1'b0;
                    end else begin
                        w_state   = RD_REQ;
                        w_araddr  = cmd_addr;
                        w_arvalid = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (w_expire) begin
                    w_abort = 1'b1;
                end else begin
                    if (w_aw_hs) begin
                        w_awvalid = 1'b0;
                        w_aw_done = 1'b1;
                    end
                    if (w_w_hs) begin
                        w_wvalid = 1'b0;
                        w_w_done = 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        w_state  = WR_RESP;
                        w_bready = 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (r_bready && bvalid) begin
                    w_state       = IDLE;
                    w_bready      = 1'b0;
                    w_cmd_ready   = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_rsp_resp    = bresp;
                    w_rsp_rdata   = '0;
                    w_rsp_timeout = 1'b0;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (w_expire) begin
                    w_abort = 1'b1;
                end else if (r_arvalid && arready) begin
                    w_state   = RD_RESP;
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_rready && rvalid) begin
                    w_state       = IDLE;
                    w_rready      = 1'b0;
                    w_cmd_ready   = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_rsp_resp    = rresp;
                    w_rsp_rdata   = rdata;
                    w_rsp_timeout = 1'b0;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // Hung-target recovery: drop every handshake output and report a timeout.
        if (w_abort) begin
            w_state       = IDLE;
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_cmd_ready   = 1'b1;
            w_rsp_valid   = 1'b1;
            w_rsp_resp    = 2'b10;
            w_rsp_rdata   = '0;
            w_rsp_timeout = 1'b1;
        end
    end

    // State and registered-output update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_awaddr      <= '0;
            r_awvalid     <= 1'b0;
            r_wdata       <= '0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_aw_done     <= w_aw_done;
            r_w_done      <= w_w_done;
            r_cmd_ready   <= w_cmd_ready;
            r_awaddr      <= w_awaddr;
            r_awvalid     <= w_awvalid;
            r_wdata       <= w_wdata;
            r_wvalid      <= w_wvalid;
            r_bready      <= w_bready;
            r_araddr      <= w_araddr;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_resp    <= w_rsp_resp;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign awaddr      = r_awaddr;
    assign awvalid     = r_awvalid;
    assign wdata       = r_wdata;
    assign wvalid      = r_wvalid;
    assign bready      = r_bready;
    assign araddr      = r_araddr;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

endmodule
